// File: rtl/instr_cache_assoc_pkg.sv
// Shared types and helpers for the set-associative instruction cache.
package instr_cache_assoc_pkg;

   localparam int WORD_BITS = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REFILL = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // Width of a way number; a direct-mapped cache still needs a 1-bit field.
   function automatic int way_bits(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/instr_cache_assoc_chk.sv
// Refill protocol checker: rlast must coincide with the final beat of the line.
module instr_cache_assoc_chk (
   input logic       clk,
   input logic       reset,
   input logic       i_req,
   input logic       i_dok,
   input logic       i_rlast,
   input logic [7:0] i_len
);

   logic [7:0] r_cnt;

   // Beats accepted so far in the current burst.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= 8'd0;
      end else if (!i_req) begin
         r_cnt <= 8'd0;
      end else if (i_dok) begin
         r_cnt <= i_rlast ? 8'd0 : r_cnt + 8'd1;
      end
   end

   a_rlast_on_last_beat: assert property (@(posedge clk) disable iff (reset)
      (i_req && i_dok && i_rlast) |-> (r_cnt == i_len));

endmodule

// File: rtl/instr_cache_assoc_way.sv
// One cache way: valid/tag/data register arrays with an index read port,
// a single-word refill write port, a tag/valid write and a whole-way flush.
module instr_cache_assoc_way
   import instr_cache_assoc_pkg::*;
#(
   parameter int INDEX_BITS  = 7,
   parameter int OFFSET_BITS = 4,
   parameter int TAG_BITS    = 21
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [INDEX_BITS-1:0]  i_rd_index,
   input  logic [OFFSET_BITS-3:0] i_rd_word,
   output logic                   o_rd_valid,
   output logic [TAG_BITS-1:0]    o_rd_tag,
   output logic [WORD_BITS-1:0]   o_rd_data,
   input  logic [INDEX_BITS-1:0]  i_wr_index,
   input  logic                   i_wr_en,
   input  logic [OFFSET_BITS-3:0] i_wr_word,
   input  logic [WORD_BITS-1:0]   i_wr_data,
   input  logic                   i_tag_we,
   input  logic [TAG_BITS-1:0]    i_wr_tag,
   input  logic                   i_flush
);

   localparam int SETS  = 1 << INDEX_BITS;
   localparam int BEATS = 1 << (OFFSET_BITS - 2);

   logic [SETS-1:0]      r_valid;
   logic [TAG_BITS-1:0]  r_tag  [SETS];
   logic [WORD_BITS-1:0] r_data [SETS*BEATS];

   assign o_rd_valid = r_valid[i_rd_index];
   assign o_rd_tag   = r_tag[i_rd_index];
   assign o_rd_data  = r_data[{i_rd_index, i_rd_word}];

   // Valid bits: only the final refill beat sets one, so partial lines never hit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= '0;
      end else if (i_flush) begin
         r_valid <= '0;
      end else if (i_tag_we) begin
         r_valid[i_wr_index] <= 1'b1;
      end
   end

   // Tag and data storage, not reset: contents are meaningless while invalid.
   always_ff @(posedge clk) begin
      if (i_tag_we) begin
         r_tag[i_wr_index] <= i_wr_tag;
      end
      if (i_wr_en) begin
         r_data[{i_wr_index, i_wr_word}] <= i_wr_data;
      end
   end

endmodule

// File: rtl/instr_cache_assoc.sv
// N-way set-associative instruction cache: same-cycle hits from register
// arrays, whole-line burst refill on a miss, round-robin replacement and flush.
module instr_cache_assoc
   import instr_cache_assoc_pkg::*;
#(
   parameter int WAYS        = 2,
   parameter int INDEX_BITS  = 7,
   parameter int OFFSET_BITS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_sram_en,
   input  logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_rdata,
   output logic        inst_sram_data_ok,
   input  logic        icache_flush,
   output logic        inst_cache_req,
   output logic [31:0] inst_cache_addr,
   output logic [7:0]  inst_cache_len,
   input  logic [31:0] inst_cache_rdata,
   input  logic        inst_cache_dok,
   input  logic        inst_cache_rlast
);

   localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS;
   localparam int SETS     = 1 << INDEX_BITS;
   localparam int BEATS    = 1 << (OFFSET_BITS - 2);
   localparam int WSEL     = OFFSET_BITS - 2;
   localparam int WB       = way_bits(WAYS);
   localparam logic [7:0] LEN = 8'(BEATS - 1);

   state_t                r_state;
   state_t                w_next;
   logic [TAG_BITS-1:0]   r_tag;
   logic [INDEX_BITS-1:0] r_index;
   logic [WSEL-1:0]       r_word;
   logic [WSEL-1:0]       r_beat;
   logic [WB-1:0]         r_victim;
   logic [31:0]           r_crit;
   logic                  r_flush_pend;

   logic [TAG_BITS-1:0]   w_tag;
   logic [INDEX_BITS-1:0] w_index;
   logic [WSEL-1:0]       w_word;
   logic [WAYS-1:0]       w_way_valid;
   logic [TAG_BITS-1:0]   w_way_tag  [WAYS];
   logic [31:0]           w_way_data [WAYS];
   logic [WAYS-1:0]       w_hit_vec;
   logic                  w_hit;
   logic [31:0]           w_hit_data;
   logic [WB-1:0]         w_rr_sel;
   logic [WB-1:0]         w_victim;
   logic                  w_miss;
   logic                  w_beat_acc;
   logic                  w_fill_done;
   logic                  w_flush_apply;
   logic                  w_unused;

   assign w_tag         = inst_sram_addr[31 -: TAG_BITS];
   assign w_index       = inst_sram_addr[OFFSET_BITS +: INDEX_BITS];
   assign w_word        = inst_sram_addr[OFFSET_BITS-1:2];
   assign w_unused      = ^inst_sram_addr[1:0];
   assign w_hit         = |w_hit_vec;
   assign w_miss        = (r_state == ST_IDLE) && inst_sram_en && !w_hit;
   assign w_beat_acc    = (r_state == ST_REFILL) && inst_cache_dok;
   assign w_fill_done   = w_beat_acc && inst_cache_rlast;
   assign w_flush_apply = (r_state == ST_IDLE) && (icache_flush || r_flush_pend);

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      instr_cache_assoc_way #(
         .INDEX_BITS (INDEX_BITS),
         .OFFSET_BITS(OFFSET_BITS),
         .TAG_BITS   (TAG_BITS)
      ) u_way (
         .clk       (clk),
         .reset     (reset),
         .i_rd_index(w_index),
         .i_rd_word (w_word),
         .o_rd_valid(w_way_valid[g]),
         .o_rd_tag  (w_way_tag[g]),
         .o_rd_data (w_way_data[g]),
         .i_wr_index(r_index),
         .i_wr_en   (w_beat_acc && (r_victim == WB'(g))),
         .i_wr_word (r_beat),
         .i_wr_data (inst_cache_rdata),
         .i_tag_we  (w_fill_done && (r_victim == WB'(g))),
         .i_wr_tag  (r_tag),
         .i_flush   (w_flush_apply)
      );
      assign w_hit_vec[g] = w_way_valid[g] && (w_way_tag[g] == w_tag);
   end

   // Per-set round-robin pointer, advanced on every completed fill of that set.
   if (WAYS > 1) begin : g_rr
      logic [WB-1:0] r_rr [SETS];
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int s = 0; s < SETS; s++) begin
               r_rr[s] <= '0;
            end
         end else if (w_fill_done) begin
            r_rr[r_index] <= r_rr[r_index] + WB'(1);
         end
      end
      assign w_rr_sel = r_rr[w_index];
   end else begin : g_dm
      assign w_rr_sel = '0;
   end

   // Hit way select; at most one way can match a given tag.
   always_comb begin
      w_hit_data = '0;
      for (int g = 0; g < WAYS; g++) begin
         w_hit_data = w_hit_data | ({32{w_hit_vec[g]}} & w_way_data[g]);
      end
   end

   // Victim: lowest-numbered invalid way, otherwise the set's pointer.
   always_comb begin
      w_victim = w_rr_sel;
      for (int g = WAYS - 1; g >= 0; g--) begin
         w_victim = w_way_valid[g] ? w_victim : WB'(g);
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   w_next = w_miss ? ST_REFILL : ST_IDLE;
         ST_REFILL: w_next = w_fill_done ? ST_RESP : ST_REFILL;
         ST_RESP:   w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // FSM outputs; refill address/length are held from the latched miss.
   always_comb begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'h0000_0000;
      inst_cache_req    = 1'b0;
      inst_cache_addr   = 32'h0000_0000;
      inst_cache_len    = 8'h00;
      case (r_state)
         ST_IDLE: begin
            if (inst_sram_en && w_hit) begin
               inst_sram_data_ok = 1'b1;
               inst_sram_rdata   = w_hit_data;
            end else begin
               inst_sram_data_ok = 1'b0;
            end
         end
         ST_REFILL: begin
            inst_cache_req  = 1'b1;
            inst_cache_addr = {r_tag, r_index, {OFFSET_BITS{1'b0}}};
            inst_cache_len  = LEN;
         end
         ST_RESP: begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = r_crit;
         end
         default: begin
            inst_sram_data_ok = 1'b0;
         end
      endcase
   end

   // Miss latch, beat counter, critical word capture and deferred flush.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tag        <= '0;
         r_index      <= '0;
         r_word       <= '0;
         r_beat       <= '0;
         r_victim     <= '0;
         r_crit       <= 32'h0000_0000;
         r_flush_pend <= 1'b0;
      end else begin
         if (w_miss) begin
            r_tag    <= w_tag;
            r_index  <= w_index;
            r_word   <= w_word;
            r_victim <= w_victim;
            r_beat   <= '0;
         end
         if (w_beat_acc) begin
            r_beat <= inst_cache_rlast ? '0 : r_beat + WSEL'(1);
            if (r_beat == r_word) begin
               r_crit <= inst_cache_rdata;
            end
         end
         if (r_state == ST_IDLE) begin
            r_flush_pend <= 1'b0;
         end else if (icache_flush) begin
            r_flush_pend <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_cache_assoc.sv
// Scoreboard bench: instance 0 (2-way, 16B lines) runs directed vectors,
// instance 1 (4-way, 32 sets, 32B lines) runs a fetch stream against a memory model.
module tb_instr_cache_assoc;

   logic        clk = 1'b0;
   logic        reset;
   logic        en     [2];
   logic [31:0] addr   [2];
   logic        flush  [2];
   logic [31:0] rdata  [2];
   logic        dok_o  [2];
   logic        req    [2];
   logic [31:0] caddr  [2];
   logic [7:0]  clen   [2];
   logic [31:0] exp_q  [2][$];
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int P_WAYS = (g == 0) ? 2 : 4;
      localparam int P_IB   = (g == 0) ? 7 : 5;
      localparam int P_OB   = (g == 0) ? 4 : 5;
      logic        cdok;
      logic        crlast;
      logic [31:0] crdata;

      instr_cache_assoc #(.WAYS(P_WAYS), .INDEX_BITS(P_IB), .OFFSET_BITS(P_OB)) u_dut (
         .clk              (clk),
         .reset            (reset),
         .inst_sram_en     (en[g]),
         .inst_sram_addr   (addr[g]),
         .inst_sram_rdata  (rdata[g]),
         .inst_sram_data_ok(dok_o[g]),
         .icache_flush     (flush[g]),
         .inst_cache_req   (req[g]),
         .inst_cache_addr  (caddr[g]),
         .inst_cache_len   (clen[g]),
         .inst_cache_rdata (crdata),
         .inst_cache_dok   (cdok),
         .inst_cache_rlast (crlast)
      );

      instr_cache_assoc_chk u_chk (
         .clk(clk), .reset(reset), .i_req(req[g]), .i_dok(cdok), .i_rlast(crlast), .i_len(clen[g])
      );

      // Burst responder with a stall cycle every fourth clock.
      initial begin
         int b;
         int tick;
         cdok = 1'b0; crlast = 1'b0; crdata = 32'h0; b = 0; tick = 0;
         forever begin
            @(posedge clk); #1;
            tick++;
            if (reset || !req[g]) begin
               cdok = 1'b0; crlast = 1'b0; b = 0;
            end else if (tick % 4 == 3) begin
               cdok = 1'b0; crlast = 1'b0;
            end else begin
               cdok   = 1'b1;
               crdata = mem_word(caddr[g] + 32'(4 * b));
               crlast = (b == int'(clen[g]));
               b++;
            end
         end
      end

      // Monitor: every data_ok retires the oldest expected word.
      always @(negedge clk) begin
         if (!reset && dok_o[g]) begin
            if (exp_q[g].size() == 0) begin
               check($sformatf("unexpected data_ok inst%0d", g), 32'd1, 32'd0);
            end else begin
               check($sformatf("rdata inst%0d", g), rdata[g], exp_q[g].pop_front());
            end
         end
      end
   end

   // Issue one fetch at posedge+1; exp_hit: 1 hit, 0 miss, -1 either.
   task automatic fetch(input int k, input logic [31:0] a, input int exp_hit);
      int lat;
      bit seen_req;
      logic req_at_hit;
      logic [31:0] mask;
      mask = (k == 0) ? 32'h0000_000F : 32'h0000_001F;
      exp_q[k].push_back(mem_word(a));
      en[k] = 1'b1;
      addr[k] = a;
      seen_req = 1'b0;
      req_at_hit = 1'b0;
      for (lat = 0; lat < 200; lat++) begin
         @(negedge clk);
         if (req[k] && !seen_req) begin
            seen_req = 1'b1;
            check("refill addr", caddr[k], a & ~mask);
            check("refill len", {24'h0, clen[k]}, (k == 0) ? 32'd3 : 32'd7);
         end
         if (dok_o[k]) begin
            req_at_hit = req[k];
            break;
         end
         @(posedge clk); #1;
      end
      if (lat == 200) begin
         check($sformatf("timeout addr %h", a), 32'd1, 32'd0);
         void'(exp_q[k].pop_back());
      end else begin
         if (exp_hit >= 0) begin
            check($sformatf("hit addr %h", a), 32'(lat == 0), 32'(exp_hit));
         end
         if (lat == 0) begin
            check("req on hit", 32'(req_at_hit), 32'd0);
         end else begin
            check("req on miss", 32'(seen_req), 32'd1);
         end
      end
      @(posedge clk); #1;
      en[k] = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, vectors %0d", n_vec);
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         en[k] = 1'b0; addr[k] = 32'h0; flush[k] = 1'b0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("reset data_ok", 32'(dok_o[k]), 32'd0);
         check("reset req", 32'(req[k]), 32'd0);
         check("reset rdata", rdata[k], 32'h0);
         check("reset caddr", caddr[k], 32'h0);
         check("reset len", {24'h0, clen[k]}, 32'h0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Cold miss returns critical word A1, then a same-cycle hit on A3.
      fetch(0, 32'h0000_1004, 0);
      fetch(0, 32'h0000_100C, 1);

      // Reset in the middle of a refill.
      en[0] = 1'b1; addr[0] = 32'h0000_2040;
      for (int i = 0; i < 50 && !req[0]; i++) @(negedge clk);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("req after reset", 32'(req[0]), 32'd0);
      check("data_ok after reset", 32'(dok_o[0]), 32'd0);
      en[0] = 1'b0;
      repeat (2) @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      fetch(0, 32'h0000_2044, 0);
      fetch(0, 32'h0000_204C, 1);

      // Three tags in set 0: the third evicts way 0 (0x0000 line).
      fetch(0, 32'h0000_0000, 0);
      fetch(0, 32'h0000_0800, 0);
      fetch(0, 32'h0000_1000, 0);
      fetch(0, 32'h0000_0804, 1);
      fetch(0, 32'h0000_0000, 0);
      fetch(0, 32'h0000_1008, 1);

      // Flush during refill: the word still returns, the line is then gone.
      fork
         fetch(0, 32'h0000_3084, 0);
         begin
            for (int i = 0; i < 50 && !req[0]; i++) @(negedge clk);
            @(posedge clk); #1;
            flush[0] = 1'b1;
            @(posedge clk); #1;
            flush[0] = 1'b0;
         end
      join
      repeat (2) @(posedge clk); #1;
      fetch(0, 32'h0000_3080, 0);
      fetch(0, 32'h0000_2048, 0);

      // Flush in IDLE: same-cycle lookup still hits, next one misses.
      flush[0] = 1'b1;
      fetch(0, 32'h0000_3088, 1);
      flush[0] = 1'b0;
      fetch(0, 32'h0000_3088, 0);

      // Idle with en low: no request, no data_ok.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle req", 32'(req[0]), 32'd0);
         check("idle data_ok", 32'(dok_o[0]), 32'd0);
      end
      @(posedge clk); #1;

      // 4-way / 32-byte lines: len 7, then a mixed fetch stream.
      fetch(1, 32'h0000_0124, 0);
      fetch(1, 32'h0000_013C, 1);
      for (int i = 0; i < 300; i++) begin
         if (i % 60 == 30) begin
            flush[1] = 1'b1;
            @(posedge clk); #1;
            flush[1] = 1'b0;
         end
         fetch(1, 32'($urandom_range(0, 32'h0FFF)) << 2, -1);
      end

      repeat (4) @(posedge clk);
      check("scoreboard drained 0", 32'(exp_q[0].size()), 32'd0);
      check("scoreboard drained 1", 32'(exp_q[1].size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
